// File: rtl/variable_sampler.sv
// Receive-path bit sampler: generates the oversampling tick, tracks bit phase with
// synchronizer corrections and samples rxd mid-bit. Define MAJORITY_VOTE_EN for a 3-tap vote.
module variable_sampler #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BIT_RATE = 50_000,
   parameter int NUM_SAMP = 16,
   parameter int W        = $clog2(NUM_SAMP) + 1,
   parameter int MAX_ADJ  = 5,
   parameter int DIV      = CLK_FREQ / (BIT_RATE * NUM_SAMP)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enb,
   input  logic         rxd,
   input  logic         slow_down,
   input  logic         speed_up,
   input  logic [W-1:0] phase_diff,
   output logic         count_enb,
   output logic         bit_out,
   output logic         bit_valid,
   output logic         bit_end
);

   localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [W-1:0]  NOM_END   = W'(NUM_SAMP - 1);
   localparam logic [W-1:0]  MAX_ADJ_W = W'(MAX_ADJ);
   localparam logic [W-1:0]  MID       = W'(NUM_SAMP / 2);

   if (NUM_SAMP - 1 + MAX_ADJ >= (1 << W)) begin : g_width_check
      $error("variable_sampler: W cannot hold NUM_SAMP-1+MAX_ADJ");
   end
   if (DIV < 2) begin : g_div_check
      $error("variable_sampler: DIV must be at least 2");
   end
   if ((NUM_SAMP < 4) || (NUM_SAMP % 2 != 0) || (NUM_SAMP <= 2 * MAX_ADJ - 2)) begin : g_samp_check
      $error("variable_sampler: NUM_SAMP must be even, >=4 and > 2*MAX_ADJ-2");
   end

   logic [DW-1:0] dcnt;
   logic [W-1:0]  ph;
   logic [W-1:0]  ph_next;
   logic [W-1:0]  adj;
   logic [W-1:0]  end_val;
   logic          adj_pending;
   logic          adj_slow;
   logic          tick_next;
   logic          close_bit;
   logic          req_ok;

   // All tick-related decisions are taken on the clk that raises count_enb, so
   // the phase seen during a count_enb pulse is the value that tick produced.
   assign tick_next = (dcnt == DIV_LAST);
   assign ph_next   = ph + W'(1);
   assign close_bit = tick_next && (ph >= end_val);
   assign req_ok    = (speed_up ^ slow_down) && (phase_diff != '0) && (phase_diff <= MAX_ADJ_W);

   always_comb begin
      end_val = NOM_END;
      if (adj_pending) begin
         end_val = adj_slow ? (NOM_END + adj) : (NOM_END - adj);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dcnt      <= '0;
         ph        <= '0;
         count_enb <= 1'b0;
         bit_end   <= 1'b0;
      end else if (!enb) begin
         dcnt      <= '0;
         ph        <= '0;
         count_enb <= 1'b0;
         bit_end   <= 1'b0;
      end else begin
         count_enb <= tick_next;
         bit_end   <= close_bit;
         dcnt      <= tick_next ? '0 : dcnt + DW'(1);
         if (tick_next) begin
            ph <= close_bit ? '0 : ph_next;
         end
      end
   end

   // A request on the boundary clk wins over the boundary clear, so it applies to the new bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         adj_pending <= 1'b0;
         adj_slow    <= 1'b0;
         adj         <= '0;
      end else if (!enb) begin
         adj_pending <= 1'b0;
         adj_slow    <= 1'b0;
         adj         <= '0;
      end else if (req_ok) begin
         adj_pending <= 1'b1;
         adj_slow    <= slow_down;
         adj         <= phase_diff;
      end else if (close_bit) begin
         adj_pending <= 1'b0;
      end
   end

`ifdef MAJORITY_VOTE_EN
   localparam logic [W-1:0] MID_LO = W'(NUM_SAMP / 2 - 1);
   localparam logic [W-1:0] MID_HI = W'(NUM_SAMP / 2 + 1);

   logic tap_lo;
   logic tap_mid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tap_lo    <= 1'b0;
         tap_mid   <= 1'b0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else if (!enb) begin
         tap_lo    <= 1'b0;
         tap_mid   <= 1'b0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else begin
         bit_valid <= 1'b0;
         if (close_bit) begin
            tap_lo  <= 1'b0;
            tap_mid <= 1'b0;
         end else if (tick_next) begin
            if (ph_next == MID_LO) begin
               tap_lo <= rxd;
            end
            if (ph_next == MID) begin
               tap_mid <= rxd;
            end
            if (ph_next == MID_HI) begin
               bit_out   <= (tap_lo & tap_mid) | (tap_lo & rxd) | (tap_mid & rxd);
               bit_valid <= 1'b1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else if (!enb) begin
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else begin
         bit_valid <= 1'b0;
         if (tick_next && !close_bit && (ph_next == MID)) begin
            bit_out   <= rxd;
            bit_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_variable_sampler.sv
// Self-checking bench for variable_sampler: directed scenarios plus random requests,
// compared every clk against a tick/phase reference model.
module tb_variable_sampler;

   localparam int CLK_FREQ = 64;
   localparam int BIT_RATE = 1;
   localparam int NUM_SAMP = 16;
   localparam int MAX_ADJ  = 5;
   localparam int DIV      = CLK_FREQ / (BIT_RATE * NUM_SAMP);
   localparam int W        = $clog2(NUM_SAMP) + 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         enb = 1'b0;
   logic         rxd = 1'b0;
   logic         slow_down = 1'b0;
   logic         speed_up = 1'b0;
   logic [W-1:0] phase_diff = '0;
   logic         count_enb;
   logic         bit_out;
   logic         bit_valid;
   logic         bit_end;

   variable_sampler #(
      .CLK_FREQ(CLK_FREQ),
      .BIT_RATE(BIT_RATE),
      .NUM_SAMP(NUM_SAMP),
      .W(W),
      .MAX_ADJ(MAX_ADJ)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enb(enb),
      .rxd(rxd),
      .slow_down(slow_down),
      .speed_up(speed_up),
      .phase_diff(phase_diff),
      .count_enb(count_enb),
      .bit_out(bit_out),
      .bit_valid(bit_valid),
      .bit_end(bit_end)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // Reference model: clocks since enable, tick index within the bit, signed pending adjustment.
   int   m_clks = 0;
   int   m_ph = 0;
   int   m_adj = 0;
   logic e_cnt = 1'b0;
   logic e_out = 1'b0;
   logic e_valid = 1'b0;
   logic e_end = 1'b0;

   int   last_end = -1;
   int   last_period = 0;
   int   last_gap = -1;
   int   first_tick = -1;
   int   ticks_seen = 0;
   bit   alt_mode = 1'b0;
   bit   rand_mode = 1'b0;
   logic vals[$];

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0b expected=%0b at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_clks  = 0;
      m_ph    = 0;
      m_adj   = 0;
      e_cnt   = 1'b0;
      e_out   = 1'b0;
      e_valid = 1'b0;
      e_end   = 1'b0;
   endtask

   task automatic model_clock();
      int end_val;
      if (!reset || !enb) begin
         model_clear();
      end else begin
         m_clks++;
         e_cnt   = ((m_clks % DIV) == 0);
         e_end   = 1'b0;
         e_valid = 1'b0;
         if (e_cnt) begin
            end_val = NUM_SAMP - 1 + m_adj;
            if (m_ph >= end_val) begin
               m_ph  = 0;
               m_adj = 0;
               e_end = 1'b1;
            end else begin
               m_ph++;
               if (m_ph == NUM_SAMP / 2) begin
                  e_out   = rxd;
                  e_valid = 1'b1;
               end
            end
         end
         if ((speed_up ^ slow_down) && phase_diff >= 1 && int'(phase_diff) <= MAX_ADJ) begin
            m_adj = slow_down ? int'(phase_diff) : -int'(phase_diff);
         end
      end
   endtask

   task automatic check_output();
      check_bit("count_enb", count_enb, e_cnt);
      check_bit("bit_out", bit_out, e_out);
      check_bit("bit_valid", bit_valid, e_valid);
      check_bit("bit_end", bit_end, e_end);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_clock();
      #1;
      check_output();
      if (count_enb === 1'b1) begin
         ticks_seen++;
         if (first_tick < 0) first_tick = cyc;
      end
      if (bit_end === 1'b1) begin
         if (last_end >= 0) last_period = cyc - last_end;
         last_end = cyc;
      end
      if (bit_valid === 1'b1) begin
         last_gap = (last_end >= 0) ? cyc - last_end : -1;
         vals.push_back(bit_out);
      end
      if (alt_mode && e_end) rxd = ~rxd;
      if (rand_mode) rxd = 1'($urandom_range(0, 1));
   endtask

   task automatic apply_stimulus(input logic su, input logic sd, input int pd);
      speed_up   = su;
      slow_down  = sd;
      phase_diff = W'(pd);
      step();
      speed_up   = 1'b0;
      slow_down  = 1'b0;
      phase_diff = '0;
   endtask

   task automatic wait_ph(input int target);
      for (int i = 0; i < 400; i++) begin
         step();
         if (e_cnt && m_ph == target) return;
      end
      check_int("wait_ph_timeout", m_ph, target);
   endtask

   task automatic wait_end();
      for (int i = 0; i < 400; i++) begin
         step();
         if (bit_end === 1'b1) return;
      end
      check_int("wait_end_timeout", 0, 1);
   endtask

   initial begin
      int en_cyc;
      int t_req;
      int ticks_before;

      // Reset held, enable low
      repeat (3) step();
      check_bit("reset_count_enb", count_enb, 1'b0);
      check_bit("reset_bit_out", bit_out, 1'b0);

      // Nominal timing with alternating rxd
      reset = 1'b1;
      enb = 1'b1;
      rxd = 1'b1;
      alt_mode = 1'b1;
      en_cyc = cyc;
      wait_end();
      check_int("first_tick_delay", first_tick - en_cyc, DIV);
      check_int("first_bit_len", cyc - en_cyc, NUM_SAMP * DIV);
      repeat (3 * NUM_SAMP * DIV + 40) step();
      check_int("nominal_period", last_period, 64);
      check_int("valid_after_end", last_gap, 32);
      check_int("nominal_bits", int'(vals.size()) >= 4 ? 1 : 0, 1);
      if (vals.size() >= 4) begin
         check_bit("alt_bit0", vals[0], 1'b1);
         check_bit("alt_bit1", vals[1], 1'b0);
         check_bit("alt_bit2", vals[2], 1'b1);
         check_bit("alt_bit3", vals[3], 1'b0);
      end
      alt_mode = 1'b0;

      // Speed-up of 3 requested at phase 5, next bit nominal again
      wait_ph(5);
      apply_stimulus(1'b1, 1'b0, 3);
      wait_end();
      check_int("speed_up_period", last_period, 52);
      wait_end();
      check_int("after_speed_period", last_period, 64);

      // Slow-down of 5 requested at phase 2
      wait_ph(2);
      apply_stimulus(1'b0, 1'b1, 5);
      wait_end();
      check_int("slow_down_period", last_period, 84);

      // Rejected requests leave the period nominal
      wait_ph(3);
      apply_stimulus(1'b1, 1'b0, 6);
      wait_end();
      check_int("reject_big_period", last_period, 64);
      wait_ph(3);
      apply_stimulus(1'b0, 1'b1, 0);
      wait_end();
      check_int("reject_zero_period", last_period, 64);
      wait_ph(3);
      apply_stimulus(1'b1, 1'b1, 3);
      wait_end();
      check_int("reject_both_period", last_period, 64);

      // Late shrink below the current phase closes on the next tick
      wait_ph(12);
      t_req = cyc;
      apply_stimulus(1'b1, 1'b0, 5);
      wait_end();
      check_int("late_shrink_delay", cyc - t_req, DIV);
      check_int("late_shrink_period", last_period, 13 * DIV);

      // Asynchronous reset mid-bit
      rxd = 1'b1;
      wait_ph(9);
      reset = 1'b0;
      #1;
      model_clear();
      check_bit("async_count_enb", count_enb, 1'b0);
      check_bit("async_bit_out", bit_out, 1'b0);
      check_bit("async_bit_valid", bit_valid, 1'b0);
      check_bit("async_bit_end", bit_end, 1'b0);
      repeat (4) step();
      reset = 1'b1;
      enb = 1'b0;
      ticks_before = ticks_seen;
      repeat (20) step();
      check_int("no_ticks_disabled", ticks_seen - ticks_before, 0);

      // Enable drop discards a pending slow-down
      enb = 1'b1;
      last_end = -1;
      wait_ph(2);
      apply_stimulus(1'b0, 1'b1, 5);
      repeat (3) step();
      enb = 1'b0;
      last_end = -1;
      repeat (10) step();
      enb = 1'b1;
      en_cyc = cyc;
      wait_end();
      check_int("reenable_first_bit", cyc - en_cyc, 64);

      // Random requests and data
      rand_mode = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 7)));
         end else if ($urandom_range(0, 299) == 0) begin
            enb = 1'b0;
            repeat (int'($urandom_range(1, 6))) step();
            enb = 1'b1;
         end else begin
            step();
         end
      end
      rand_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
